// File: rtl/accessor.sv
// ---------------------------------------------------------------------------
// accessor : memory-access pipeline stage.
//
// Consumer end of the executor->accessor link. Takes one op per handshake.
// Loads and stores go out on a single-outstanding memory bus. Every other op
// goes straight to the result register. The result {rd, rd_data} is offered
// to writeback on a second valid/ready pair.
//
// Handshake rule (both links): a transfer happens on a posedge where valid
// and ready are both high. A producer holds valid and its payload stable
// until that transfer. ready may depend on the consumer's state only.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset (0 = reset)
//   executor_*          op in: valid, rd, rd_data, mem_addr, mem_data, is_*
//   accessor_ready      stage idle and able to accept an op
//   mem_valid/ready     bus request / completion
//   mem_addr            word-aligned request address
//   mem_wdata/wstrb     lane-replicated store data / byte enables (0 = read)
//   mem_rdata           read data, valid when mem_valid && mem_ready
//   accessor_valid      result on offer to writeback
//   writeback_ready     writeback takes the result
//   accessor_rd/rd_data result (rd=0 and rd_data=0 for stores)
//   accessor_trap       misaligned access flag (constant 0 unless enabled)
//   debug_state         current FSM state (IDLE=0, MEM=1, DONE=2)
//
// Build option: define MISALIGNED_TRAP_EN to turn misaligned lh/lhu/sh/lw/sw
// into trapping ops that never reach the bus.
// ---------------------------------------------------------------------------
module accessor (
  input  logic        clk,
  input  logic        reset,
  input  logic        executor_valid,
  output logic        accessor_ready,
  input  logic [4:0]  executor_rd,
  input  logic [31:0] executor_rd_data,
  input  logic [31:0] executor_mem_addr,
  input  logic [31:0] executor_mem_data,
  input  logic        executor_is_lui,
  input  logic        executor_is_lb,
  input  logic        executor_is_lbu,
  input  logic        executor_is_lh,
  input  logic        executor_is_lhu,
  input  logic        executor_is_lw,
  input  logic        executor_is_sb,
  input  logic        executor_is_sh,
  input  logic        executor_is_sw,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        accessor_valid,
  input  logic        writeback_ready,
  output logic [4:0]  accessor_rd,
  output logic [31:0] accessor_rd_data,
  output logic        accessor_trap,
  output logic [1:0]  debug_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  // Low while in reset and until the first clock edge after release, so the
  // stage never advertises ready while reset is asserted.
  logic        live;

  // Captured load attributes for result extraction when the bus completes.
  logic        cap_lb;
  logic        cap_lbu;
  logic        cap_lh;
  logic        cap_lhu;
  logic        cap_store;
  logic [1:0]  cap_lane;
  logic [4:0]  cap_rd;

  logic        take;
  logic        in_load;
  logic        in_store;
  logic [1:0]  in_lane;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  assign accessor_ready = live && (state == IDLE);
  assign take           = executor_valid && accessor_ready;
  assign debug_state    = state;

  assign in_load  = executor_is_lb | executor_is_lbu | executor_is_lh |
                    executor_is_lhu | executor_is_lw;
  assign in_store = executor_is_sb | executor_is_sh | executor_is_sw;
  assign in_lane  = executor_mem_addr[1:0];

`ifdef MISALIGNED_TRAP_EN
  assign misaligned = ((executor_is_lh | executor_is_lhu | executor_is_sh) && in_lane[0]) ||
                      ((executor_is_lw | executor_is_sw) && (in_lane != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Store byte enables and lane-replicated data from the incoming op.
  always_comb begin
    st_strb  = 4'h0;
    st_wdata = 32'h0;
    if (executor_is_sb) begin
      st_strb  = 4'b0001 << in_lane;
      st_wdata = {4{executor_mem_data[7:0]}};
    end else if (executor_is_sh) begin
      st_strb  = in_lane[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{executor_mem_data[15:0]}};
    end else if (executor_is_sw) begin
      st_strb  = 4'hF;
      st_wdata = executor_mem_data;
    end
  end

  // Load result: byte selected by the low address bits, half by bit 1.
  always_comb begin
    ld_byte = 8'h0;
    case (cap_lane)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = cap_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (cap_lb)
      ld_result = {{24{ld_byte[7]}}, ld_byte};
    else if (cap_lbu)
      ld_result = {24'h0, ld_byte};
    else if (cap_lh)
      ld_result = {{16{ld_half[15]}}, ld_half};
    else if (cap_lhu)
      ld_result = {16'h0, ld_half};
    else
      ld_result = mem_rdata;
  end

`ifdef MISALIGNED_TRAP_EN
  logic trap_q;
  assign accessor_trap = trap_q;
`else
  assign accessor_trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      live             <= 1'b0;
      mem_valid        <= 1'b0;
      mem_addr         <= 32'h0;
      mem_wdata        <= 32'h0;
      mem_wstrb        <= 4'h0;
      accessor_valid   <= 1'b0;
      accessor_rd      <= 5'd0;
      accessor_rd_data <= 32'h0;
      cap_lb           <= 1'b0;
      cap_lbu          <= 1'b0;
      cap_lh           <= 1'b0;
      cap_lhu          <= 1'b0;
      cap_store        <= 1'b0;
      cap_lane         <= 2'd0;
      cap_rd           <= 5'd0;
`ifdef MISALIGNED_TRAP_EN
      trap_q           <= 1'b0;
`endif
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (take) begin
            if (misaligned) begin
              // Trapping op: report the original byte address, no bus cycle.
              state            <= DONE;
              accessor_valid   <= 1'b1;
              accessor_rd      <= 5'd0;
              accessor_rd_data <= executor_mem_addr;
`ifdef MISALIGNED_TRAP_EN
              trap_q           <= 1'b1;
`endif
            end else if (in_load || in_store) begin
              state     <= MEM;
              mem_valid <= 1'b1;
              mem_addr  <= {executor_mem_addr[31:2], 2'b00};
              mem_wdata <= st_wdata;
              mem_wstrb <= st_strb;
              cap_lb    <= executor_is_lb;
              cap_lbu   <= executor_is_lbu;
              cap_lh    <= executor_is_lh;
              cap_lhu   <= executor_is_lhu;
              cap_store <= in_store;
              cap_lane  <= in_lane;
              cap_rd    <= in_store ? 5'd0 : executor_rd;
            end else begin
              state            <= DONE;
              accessor_valid   <= 1'b1;
              accessor_rd      <= executor_rd;
              accessor_rd_data <= executor_is_lui ? executor_mem_addr : executor_rd_data;
            end
          end
        end
        MEM: begin
          // Request stays up with stable address/data until the bus completes.
          if (mem_ready) begin
            state            <= DONE;
            mem_valid        <= 1'b0;
            accessor_valid   <= 1'b1;
            accessor_rd      <= cap_rd;
            accessor_rd_data <= cap_store ? 32'h0 : ld_result;
          end
        end
        DONE: begin
          if (writeback_ready) begin
            state          <= IDLE;
            accessor_valid <= 1'b0;
`ifdef MISALIGNED_TRAP_EN
            trap_q         <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
